dma_bus_arb: RTL and testbench

DMA_BUS_ARB -- requirements
Module: dma_bus_arb

---
 rtl/dma_bus_arb.sv | 227 ++++++++++++++++++++++
 tb/tb_dma_bus_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_arb.sv
// -----------------------------------------------------------------------------
// dma_bus_arb
//
// Arbitrates the shared memory bus between the DSP DMA engine and the blitter.
// The arbiter requests the bus from the CPU, grants it to one DMA master at a
// time (DSP has fixed priority), hands over directly between masters without
// releasing the CPU request, and never moves a grant while a DMA memory cycle
// is in flight. A blitter grant yields to a waiting DSP after BLT_BURST cycles.
//
// Optional feature (macro DMA_ARB_TIMEOUT_EN): CPU-acknowledge timeout. When
// defined, an ACQ phase that waits TO_CYC cycles for the acknowledge aborts
// back to IDLE, pulses abort and sets the sticky toerr flag. When undefined,
// ACQ waits indefinitely and abort/toerr are tied low.
//
// Parameters:
//   BLT_BURST  blitter grant cycles before yielding to a pending DSP (1..15)
//   TO_CYC     acknowledge timeout in clk cycles (1..255, timeout build only)
//
// Ports:
//   clk      in   system clock, rising edge
//   resetl   in   asynchronous active-low reset
//   dspreq   in   DSP bus request (level, active high)
//   bltreq   in   blitter bus request (level, active high)
//   busakl   in   CPU bus acknowledge (active low)
//   dmacyc   in   DMA memory cycle in progress (active high)
//   busreql  out  bus request to CPU (active low)
//   dspbak   out  DSP grant / dspbakl its complement
//   bltbak   out  blitter grant / bltbakl its complement
//   abort    out  one-cycle pulse on acknowledge timeout
//   toerr    out  sticky timeout flag
// -----------------------------------------------------------------------------
module dma_bus_arb #(
    parameter int BLT_BURST = 8,
    parameter int TO_CYC    = 255
) (
    input  logic clk,
    input  logic resetl,
    input  logic dspreq,
    input  logic bltreq,
    input  logic busakl,
    input  logic dmacyc,
    output logic busreql,
    output logic dspbak,
    output logic dspbakl,
    output logic bltbak,
    output logic bltbakl,
    output logic abort,
    output logic toerr
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACQ  = 3'd1,
        ST_DSPG = 3'd2,
        ST_BLTG = 3'd3,
        ST_REL  = 3'd4
    } state_t;

    // Elaboration-time range guards on the parameters.
    if (BLT_BURST < 1 || BLT_BURST > 15) begin : g_bad_blt_burst
        $error("dma_bus_arb: BLT_BURST out of range 1..15");
    end
    if (TO_CYC < 1 || TO_CYC > 255) begin : g_bad_to_cyc
        $error("dma_bus_arb: TO_CYC out of range 1..255");
    end

    localparam logic [3:0] BURST_MAX  = 4'(BLT_BURST);
    // Counter value seen on the edge that completes grant cycle BLT_BURST.
    localparam logic [3:0] BURST_LAST = 4'(BLT_BURST - 1);

    state_t     state_r;
    state_t     state_s;
    logic [3:0] burst_cnt_r;
    logic [3:0] burst_cnt_s;
    logic       burst_done_s;
    logic       busreql_r;
    logic       dspbak_r;
    logic       dspbakl_r;
    logic       bltbak_r;
    logic       bltbakl_r;

`ifdef DMA_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);
    logic [7:0] to_cnt_r;
    logic [7:0] to_cnt_s;
    logic       timeout_s;
    logic       abort_r;
    logic       toerr_r;
`endif

    assign burst_done_s = (burst_cnt_r >= BURST_LAST);

    // Next-state decision; every grant move is gated by dmacyc being low.
    always_comb begin
        state_s = state_r;
`ifdef DMA_ARB_TIMEOUT_EN
        timeout_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (dspreq || bltreq) begin
                    state_s = ST_ACQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACQ: begin
                if (!busakl) begin
                    if (dspreq) begin
                        state_s = ST_DSPG;
                    end else if (bltreq) begin
                        state_s = ST_BLTG;
                    end else begin
                        state_s = ST_REL;
                    end
                end else if (!dspreq && !bltreq) begin
                    state_s = ST_IDLE;
`ifdef DMA_ARB_TIMEOUT_EN
                end else if (to_cnt_r == TO_LAST) begin
                    state_s   = ST_IDLE;
                    timeout_s = 1'b1;
`endif
                end else begin
                    state_s = ST_ACQ;
                end
            end
            ST_DSPG: begin
                if (!dspreq && !dmacyc) begin
                    state_s = bltreq ? ST_BLTG : ST_REL;
                end else begin
                    state_s = ST_DSPG;
                end
            end
            ST_BLTG: begin
                if (!dmacyc && (!bltreq || (burst_done_s && dspreq))) begin
                    state_s = dspreq ? ST_DSPG : ST_REL;
                end else begin
                    state_s = ST_BLTG;
                end
            end
            ST_REL: begin
                // New requests are deliberately ignored until the CPU lets go.
                if (busakl) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REL;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Burst counter: zero on BLTG entry, counts grant cycles, saturates.
    always_comb begin
        burst_cnt_s = 4'd0;
        if (state_r == ST_BLTG && state_s == ST_BLTG) begin
            if (burst_cnt_r < BURST_MAX) begin
                burst_cnt_s = burst_cnt_r + 4'd1;
            end else begin
                burst_cnt_s = burst_cnt_r;
            end
        end else begin
            burst_cnt_s = 4'd0;
        end
    end

    // State, counter and registered output decode of the next state.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state_r     <= ST_IDLE;
            burst_cnt_r <= 4'd0;
            busreql_r   <= 1'b1;
            dspbak_r    <= 1'b0;
            dspbakl_r   <= 1'b1;
            bltbak_r    <= 1'b0;
            bltbakl_r   <= 1'b1;
        end else begin
            state_r     <= state_s;
            burst_cnt_r <= burst_cnt_s;
            busreql_r   <= !(state_s == ST_ACQ || state_s == ST_DSPG || state_s == ST_BLTG);
            dspbak_r    <= (state_s == ST_DSPG);
            dspbakl_r   <= (state_s != ST_DSPG);
            bltbak_r    <= (state_s == ST_BLTG);
            bltbakl_r   <= (state_s != ST_BLTG);
        end
    end

`ifdef DMA_ARB_TIMEOUT_EN
    // Acknowledge-wait counter: zero on ACQ entry, counts while ACQ persists.
    always_comb begin
        to_cnt_s = 8'd0;
        if (state_r == ST_ACQ && state_s == ST_ACQ) begin
            to_cnt_s = to_cnt_r + 8'd1;
        end else begin
            to_cnt_s = 8'd0;
        end
    end

    // Timeout counter, abort pulse and sticky error flag.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            to_cnt_r <= 8'd0;
            abort_r  <= 1'b0;
            toerr_r  <= 1'b0;
        end else begin
            to_cnt_r <= to_cnt_s;
            abort_r  <= timeout_s;
            toerr_r  <= toerr_r | timeout_s;
        end
    end

    assign abort = abort_r;
    assign toerr = toerr_r;
`else
    assign abort = 1'b0;
    assign toerr = 1'b0;
`endif

    assign busreql = busreql_r;
    assign dspbak  = dspbak_r;
    assign dspbakl = dspbakl_r;
    assign bltbak  = bltbak_r;
    assign bltbakl = bltbakl_r;

endmodule

// File: tb/tb_dma_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_dma_bus_arb
//
// Self-checking bench for dma_bus_arb. A behavioural reference model tracks
// who owns the bus and how long the current phase has lasted, and is stepped
// once per rising edge with the sampled inputs. Outputs are compared 1 time
// unit after each edge. Directed sequences cover reset, the DSP and blitter
// grant paths, priority, burst yield, dmacyc holding, async reset mid-grant
// and acknowledge timeout; randomized traffic follows.
// -----------------------------------------------------------------------------
module tb_dma_bus_arb;

    localparam int BURST = 8;
    localparam int TOC   = 4;
`ifdef DMA_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetl;
    logic dspreq;
    logic bltreq;
    logic busakl;
    logic dmacyc;
    logic busreql;
    logic dspbak;
    logic dspbakl;
    logic bltbak;
    logic bltbakl;
    logic abort;
    logic toerr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dma_bus_arb #(
        .BLT_BURST(BURST),
        .TO_CYC   (TOC)
    ) dut (
        .clk    (clk),
        .resetl (resetl),
        .dspreq (dspreq),
        .bltreq (bltreq),
        .busakl (busakl),
        .dmacyc (dmacyc),
        .busreql(busreql),
        .dspbak (dspbak),
        .dspbakl(dspbakl),
        .bltbak (bltbak),
        .bltbakl(bltbakl),
        .abort  (abort),
        .toerr  (toerr)
    );

    // ---------------- reference model ----------------
    // Bus ownership phases as named by the arbiter's behaviour.
    localparam int P_IDLE = 0;
    localparam int P_ACQ  = 1;
    localparam int P_DSP  = 2;
    localparam int P_BLT  = 3;
    localparam int P_REL  = 4;

    int   m_phase;
    int   m_acq_wait;     // ACQ cycles spent waiting for acknowledge
    int   m_grant_cyc;    // blitter grant cycles completed
    logic m_abort;
    logic m_toerr;

    task automatic model_reset();
        m_phase     = P_IDLE;
        m_acq_wait  = 0;
        m_grant_cyc = 0;
        m_abort     = 1'b0;
        m_toerr     = 1'b0;
    endtask

    task automatic enter_blt();
        m_phase     = P_BLT;
        m_grant_cyc = 0;
    endtask

    task automatic model_step();
        m_abort = 1'b0;
        case (m_phase)
            P_IDLE: if (dspreq || bltreq) begin
                m_phase    = P_ACQ;
                m_acq_wait = 0;
            end
            P_ACQ: begin
                if (!busakl) begin
                    if (dspreq) m_phase = P_DSP;
                    else if (bltreq) enter_blt();
                    else m_phase = P_REL;
                end else if (!dspreq && !bltreq) begin
                    m_phase = P_IDLE;
                end else if (TO_EN) begin
                    m_acq_wait++;
                    if (m_acq_wait == TOC) begin
                        m_phase = P_IDLE;
                        m_abort = 1'b1;
                        m_toerr = 1'b1;
                    end
                end
            end
            P_DSP: if (!dspreq && !dmacyc) begin
                if (bltreq) enter_blt();
                else m_phase = P_REL;
            end
            P_BLT: begin
                if (m_grant_cyc < 15) m_grant_cyc++;
                if (!dmacyc && (!bltreq || (m_grant_cyc >= BURST && dspreq)))
                    m_phase = dspreq ? P_DSP : P_REL;
            end
            P_REL: if (busakl) m_phase = P_IDLE;
            default: m_phase = P_IDLE;
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic on_bus;
        on_bus = (m_phase == P_ACQ) || (m_phase == P_DSP) || (m_phase == P_BLT);
        check_bit("busreql", busreql, !on_bus);
        check_bit("dspbak",  dspbak,  m_phase == P_DSP);
        check_bit("dspbakl", dspbakl, m_phase != P_DSP);
        check_bit("bltbak",  bltbak,  m_phase == P_BLT);
        check_bit("bltbakl", bltbakl, m_phase != P_BLT);
        check_bit("abort",   abort,   m_abort);
        check_bit("toerr",   toerr,   m_toerr);
        check_bit("grant_excl", dspbak & bltbak, 1'b0);
    endtask

    // Apply inputs just after an edge, then step and check at the next edge.
    task automatic cycle(input logic d, input logic b, input logic a, input logic c);
        dspreq = d;
        bltreq = b;
        busakl = a;
        dmacyc = c;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    // Assert reset between edges and check that outputs drop without a clock.
    task automatic async_reset();
        #2;
        resetl = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        resetl = 1'b1;
    endtask

    initial begin
        resetl = 1'b0;
        dspreq = 1'b0;
        bltreq = 1'b0;
        busakl = 1'b1;
        dmacyc = 1'b0;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        resetl = 1'b1;

        // DSP grant, release and return to idle.
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);   // CPU reclaim ignored
        cycle(1'b0, 1'b0, 1'b0, 1'b1);   // held by dmacyc
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);   // request ignored in REL
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Simultaneous requests: DSP first, direct handover to blitter.
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        // Burst yield: DSP rises in grant cycle 2.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        // Handover condition held off by dmacyc for 3 cycles.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        // Async reset during blitter grant with dmacyc high.
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        async_reset();

        // Acknowledge never arrives.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic d, b, a, c;
            d = ($urandom_range(0, 4) == 0) ? ~dspreq : dspreq;
            b = ($urandom_range(0, 4) == 0) ? ~bltreq : bltreq;
            a = ($urandom_range(0, 2) == 0) ? ~busakl : busakl;
            c = ($urandom_range(0, 9) < 4);
            cycle(d, b, a, c);
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
